// File: rtl/regfile_arbiter.sv
// Two-requester arbiter in front of an 8 x 16-bit register file.
// Arbitration alternates between requesters after every transfer; a clear
// sequence zeroes R0-R7 after reset (optional) or on a clear_start pulse.
module regfile_arbiter #(
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        clear_start,
    output logic        busy,
    input  logic        req0_valid,
    input  logic        req0_we,
    input  logic [2:0]  req0_addr,
    input  logic [15:0] req0_wdata,
    output logic        req0_ready,
    output logic        req0_rvalid,
    output logic [15:0] req0_rdata,
    input  logic        req1_valid,
    input  logic        req1_we,
    input  logic [2:0]  req1_addr,
    input  logic [15:0] req1_wdata,
    output logic        req1_ready,
    output logic        req1_rvalid,
    output logic [15:0] req1_rdata,
    output logic        rf_load,
    output logic [2:0]  rf_dr,
    output logic [15:0] rf_bus,
    output logic [2:0]  rf_sr1,
    input  logic [15:0] rf_sr1out
);

    localparam logic StClear = 1'b0;
    localparam logic StIdle  = 1'b1;

    logic        state_q, state_d;
    logic [2:0]  clr_cnt_q, clr_cnt_d;
    logic        prio_q, prio_d;
    logic        rvalid0_q, rvalid1_q;
    logic [15:0] rdata0_q, rdata1_q;

    logic        arb_open;
    logic        grant0, grant1;
    logic        read0, read1;

    // Grant decision: only in IDLE, never in a clear_start cycle, never under Reset.
    always_comb begin
        arb_open = (state_q == StIdle) && !clear_start && !Reset;
        grant0   = arb_open && req0_valid && (!req1_valid || !prio_q);
        grant1   = arb_open && req1_valid && (!req0_valid || prio_q);
        read0    = grant0 && !req0_we;
        read1    = grant1 && !req1_we;
    end

    assign req0_ready  = grant0;
    assign req1_ready  = grant1;
    assign busy        = (state_q == StClear);
    assign req0_rvalid = rvalid0_q;
    assign req1_rvalid = rvalid1_q;
    assign req0_rdata  = rdata0_q;
    assign req1_rdata  = rdata1_q;

    // Register-file port drive: clear writes, granted writes, granted read select.
    always_comb begin
        rf_load = 1'b0;
        rf_dr   = 3'd0;
        rf_bus  = 16'h0000;
        rf_sr1  = 3'd0;
        if (!Reset && state_q == StClear) begin
            rf_load = 1'b1;
            rf_dr   = clr_cnt_q;
        end else if (grant0) begin
            if (req0_we) begin
                rf_load = 1'b1;
                rf_dr   = req0_addr;
                rf_bus  = req0_wdata;
            end else begin
                rf_sr1  = req0_addr;
            end
        end else if (grant1) begin
            if (req1_we) begin
                rf_load = 1'b1;
                rf_dr   = req1_addr;
                rf_bus  = req1_wdata;
            end else begin
                rf_sr1  = req1_addr;
            end
        end
    end

    // Next-state: clear counter walk, clear entry, priority toggle on transfer.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        prio_d    = prio_q;
        if (state_q == StClear) begin
            clr_cnt_d = clr_cnt_q + 3'd1;
            if (clr_cnt_q == 3'd7) begin
                state_d   = StIdle;
                clr_cnt_d = 3'd0;
            end
        end else if (clear_start) begin
            state_d   = StClear;
            clr_cnt_d = 3'd0;
        end
        if (grant0) begin
            prio_d = 1'b1;
        end else if (grant1) begin
            prio_d = 1'b0;
        end
    end

    // State, priority and read-return registers; Reset wins over everything.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= (CLEAR_ON_RESET != 0) ? StClear : StIdle;
            clr_cnt_q <= 3'd0;
            prio_q    <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= 16'h0000;
            rdata1_q  <= 16'h0000;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            prio_q    <= prio_d;
            rvalid0_q <= read0;
            rvalid1_q <= read1;
            if (read0) begin
                rdata0_q <= rf_sr1out;
            end
            if (read1) begin
                rdata1_q <= rf_sr1out;
            end
        end
    end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Self-checking bench for regfile_arbiter with a behavioural register file
// and a cycle-level reference model for randomized traffic.
module tb_regfile_arbiter;

    logic        Clk;
    logic        Reset;
    logic        clear_start;
    logic        busy;
    logic        req0_valid, req1_valid;
    logic        req0_we, req1_we;
    logic [2:0]  req0_addr, req1_addr;
    logic [15:0] req0_wdata, req1_wdata;
    logic        req0_ready, req1_ready;
    logic        req0_rvalid, req1_rvalid;
    logic [15:0] req0_rdata, req1_rdata;
    logic        rf_load;
    logic [2:0]  rf_dr;
    logic [15:0] rf_bus;
    logic [2:0]  rf_sr1;
    logic [15:0] rf_sr1out;

    logic [15:0] rf_mem [8];

    int checks   = 0;
    int failures = 0;

    regfile_arbiter #(.CLEAR_ON_RESET(1)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .clear_start (clear_start),
        .busy        (busy),
        .req0_valid  (req0_valid),
        .req0_we     (req0_we),
        .req0_addr   (req0_addr),
        .req0_wdata  (req0_wdata),
        .req0_ready  (req0_ready),
        .req0_rvalid (req0_rvalid),
        .req0_rdata  (req0_rdata),
        .req1_valid  (req1_valid),
        .req1_we     (req1_we),
        .req1_addr   (req1_addr),
        .req1_wdata  (req1_wdata),
        .req1_ready  (req1_ready),
        .req1_rvalid (req1_rvalid),
        .req1_rdata  (req1_rdata),
        .rf_load     (rf_load),
        .rf_dr       (rf_dr),
        .rf_bus      (rf_bus),
        .rf_sr1      (rf_sr1),
        .rf_sr1out   (rf_sr1out)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Register file behind the arbiter.
    always @(posedge Clk) begin
        if (rf_load) rf_mem[rf_dr] <= rf_bus;
    end
    assign rf_sr1out = rf_mem[rf_sr1];

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        clear_start = 1'b0;
        req0_valid = 1'b0; req0_we = 1'b0; req0_addr = 3'd0; req0_wdata = 16'h0;
        req1_valid = 1'b0; req1_we = 1'b0; req1_addr = 3'd0; req1_wdata = 16'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        Reset = 1'b1;
        cyc();
        Reset = 1'b0;
        repeat (8) cyc();
    endtask

    task automatic test_reset();
        idle_inputs();
        Reset = 1'b1;
        cyc();
        cyc();
        Reset = 1'b0;
        #1;
        checks++;
        if ({req0_rvalid, req1_rvalid, req0_rdata, req1_rdata} !== {2'b00, 32'h0}) begin
            failures++;
            $display("FAIL reset_rd got %b%b %h %h want 00 0000 0000",
                     req0_rvalid, req1_rvalid, req0_rdata, req1_rdata);
        end
        for (int i = 0; i < 8; i++) begin
            req0_valid = 1'b1;
            #1;
            checks++;
            if ({busy, rf_load, rf_dr, rf_bus, req0_ready} !== {2'b11, i[2:0], 16'h0, 1'b0}) begin
                failures++;
                $display("FAIL clear_step%0d got busy=%b load=%b dr=%0d bus=%h rdy=%b want 1 1 %0d 0000 0",
                         i, busy, rf_load, rf_dr, rf_bus, req0_ready, i);
            end
            cyc();
        end
        req0_valid = 1'b0;
        #1;
        checks++;
        if ({busy, rf_load} !== 2'b00) begin
            failures++;
            $display("FAIL clear_done got busy=%b load=%b want 0 0", busy, rf_load);
        end
    endtask

    task automatic test_write_read();
        do_reset();
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 3'd3; req0_wdata = 16'hBEEF;
        #1;
        checks++;
        if ({req0_ready, rf_load, rf_dr, rf_bus} !== {2'b11, 3'd3, 16'hBEEF}) begin
            failures++;
            $display("FAIL wr_grant got rdy=%b load=%b dr=%0d bus=%h want 1 1 3 beef",
                     req0_ready, rf_load, rf_dr, rf_bus);
        end
        cyc();
        req0_we = 1'b0;
        #1;
        checks++;
        if ({req0_ready, rf_load, rf_sr1} !== {2'b10, 3'd3}) begin
            failures++;
            $display("FAIL rd_grant got rdy=%b load=%b sr1=%0d want 1 0 3",
                     req0_ready, rf_load, rf_sr1);
        end
        cyc();
        idle_inputs();
        #1;
        checks++;
        if ({req0_rvalid, req0_rdata} !== {1'b1, 16'hBEEF}) begin
            failures++;
            $display("FAIL rd_return got rv=%b data=%h want 1 beef", req0_rvalid, req0_rdata);
        end
        cyc();
        checks++;
        if ({req0_rvalid, req0_rdata, rf_sr1} !== {1'b0, 16'hBEEF, 3'd0}) begin
            failures++;
            $display("FAIL rd_hold got rv=%b data=%h sr1=%0d want 0 beef 0",
                     req0_rvalid, req0_rdata, rf_sr1);
        end
    endtask

    task automatic test_alternate();
        do_reset();
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 3'd1;
        req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 3'd2;
        for (int k = 0; k < 6; k++) begin
            req0_wdata = 16'($urandom);
            req1_wdata = 16'($urandom);
            #1;
            checks++;
            if (k % 2 == 0) begin
                if ({req0_ready, req1_ready, rf_dr, rf_bus} !== {2'b10, 3'd1, req0_wdata}) begin
                    failures++;
                    $display("FAIL alt%0d got rdy=%b%b dr=%0d bus=%h want 10 1 %h",
                             k, req0_ready, req1_ready, rf_dr, rf_bus, req0_wdata);
                end
            end else begin
                if ({req0_ready, req1_ready, rf_dr, rf_bus} !== {2'b01, 3'd2, req1_wdata}) begin
                    failures++;
                    $display("FAIL alt%0d got rdy=%b%b dr=%0d bus=%h want 01 2 %h",
                             k, req0_ready, req1_ready, rf_dr, rf_bus, req1_wdata);
                end
            end
            cyc();
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        logic [15:0] vals [4];
        int          order [4];
        do_reset();
        order = '{2, 0, 3, 1};
        for (int a = 0; a < 4; a++) begin
            vals[a] = 16'($urandom);
            req1_valid = 1'b1; req1_we = 1'b1; req1_addr = a[2:0]; req1_wdata = vals[a];
            cyc();
        end
        req1_we = 1'b0;
        for (int k = 0; k <= 4; k++) begin
            if (k < 4) begin
                req1_addr = order[k][2:0];
            end else begin
                req1_valid = 1'b0;
            end
            #1;
            checks++;
            if (k < 4 && req1_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_grant%0d got rdy=%b want 1", k, req1_ready);
            end
            if (k > 0) begin
                checks++;
                if ({req1_rvalid, req1_rdata} !== {1'b1, vals[order[k-1]]}) begin
                    failures++;
                    $display("FAIL b2b_data%0d got rv=%b data=%h want 1 %h",
                             k - 1, req1_rvalid, req1_rdata, vals[order[k-1]]);
                end
            end
            cyc();
        end
        checks++;
        if (req1_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end got rv=%b want 0", req1_rvalid);
        end
    endtask

    task automatic test_clear_start();
        logic [15:0] v;
        idle_inputs();
        v = 16'($urandom_range(1, 16'hFFFF));
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 3'd5; req0_wdata = v;
        cyc();
        req0_we = 1'b0;
        clear_start = 1'b1;
        for (int c = 0; c < 9; c++) begin
            clear_start = (c == 0 || c == 3);
            #1;
            checks++;
            if ({req0_ready, busy} !== {1'b0, (c != 0)}) begin
                failures++;
                $display("FAIL clr_hold%0d got rdy=%b busy=%b want 0 %b",
                         c, req0_ready, busy, (c != 0));
            end
            cyc();
        end
        clear_start = 1'b0;
        #1;
        checks++;
        if ({req0_ready, busy, rf_sr1} !== {2'b10, 3'd5}) begin
            failures++;
            $display("FAIL clr_grant got rdy=%b busy=%b sr1=%0d want 1 0 5",
                     req0_ready, busy, rf_sr1);
        end
        cyc();
        idle_inputs();
        #1;
        checks++;
        if ({req0_rvalid, req0_rdata} !== {1'b1, 16'h0000}) begin
            failures++;
            $display("FAIL clr_read got rv=%b data=%h want 1 0000", req0_rvalid, req0_rdata);
        end
    endtask

    task automatic test_reset_mid_clear();
        idle_inputs();
        Reset = 1'b1;
        cyc();
        Reset = 1'b0;
        repeat (4) cyc();
        checks++;
        if ({busy, rf_dr} !== {1'b1, 3'd4}) begin
            failures++;
            $display("FAIL mid_pre got busy=%b dr=%0d want 1 4", busy, rf_dr);
        end
        Reset = 1'b1;
        cyc();
        Reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++;
            if ({busy, rf_load, rf_dr} !== {2'b11, i[2:0]}) begin
                failures++;
                $display("FAIL mid_restart%0d got busy=%b load=%b dr=%0d want 1 1 %0d",
                         i, busy, rf_load, rf_dr, i);
            end
            cyc();
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_done got busy=%b want 0", busy);
        end
        // A read presented together with Reset must not be granted or returned.
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 3'd2;
        Reset = 1'b1;
        #1;
        checks++;
        if ({req0_ready, rf_load} !== 2'b00) begin
            failures++;
            $display("FAIL rst_prio got rdy=%b load=%b want 0 0", req0_ready, rf_load);
        end
        cyc();
        Reset = 1'b0;
        idle_inputs();
        #1;
        checks++;
        if ({req0_rvalid, busy} !== 2'b01) begin
            failures++;
            $display("FAIL rst_abort got rv=%b busy=%b want 0 1", req0_rvalid, busy);
        end
        repeat (8) cyc();
    endtask

    task automatic test_random();
        logic [15:0] mregs [8];
        int          turn, clr_left, w;
        logic        cur_rv0, cur_rv1, nxt_rv0, nxt_rv1;
        logic [15:0] cur_rd0, cur_rd1;
        logic        e_r0, e_r1, e_busy, e_load;
        logic [2:0]  e_dr, e_sr1;
        logic [15:0] e_bus;
        logic [59:0] got, want;
        do_reset();
        for (int a = 0; a < 8; a++) mregs[a] = 16'h0;
        turn = 0; clr_left = 0;
        cur_rv0 = 1'b0; cur_rv1 = 1'b0; cur_rd0 = 16'h0; cur_rd1 = 16'h0;
        for (int n = 0; n < 400; n++) begin
            clear_start = ($urandom_range(0, 39) == 0);
            req0_valid = ($urandom_range(0, 9) < 7);
            req1_valid = ($urandom_range(0, 9) < 7);
            req0_we = 1'($urandom); req1_we = 1'($urandom);
            req0_addr = 3'($urandom); req1_addr = 3'($urandom);
            req0_wdata = 16'($urandom); req1_wdata = 16'($urandom);
            #1;
            e_r0 = 0; e_r1 = 0; e_load = 0; e_dr = 0; e_bus = 0; e_sr1 = 0;
            nxt_rv0 = 0; nxt_rv1 = 0;
            e_busy = (clr_left > 0);
            if (clr_left > 0) begin
                e_load = 1; e_dr = 3'(8 - clr_left);
                clr_left--;
            end else if (clear_start) begin
                clr_left = 8;
                for (int a = 0; a < 8; a++) mregs[a] = 16'h0;
            end else begin
                w = -1;
                if (req0_valid && req1_valid) w = turn;
                else if (req0_valid) w = 0;
                else if (req1_valid) w = 1;
                if (w == 0) begin
                    e_r0 = 1;
                    if (req0_we) begin
                        e_load = 1; e_dr = req0_addr; e_bus = req0_wdata;
                        mregs[req0_addr] = req0_wdata;
                    end else begin
                        e_sr1 = req0_addr; nxt_rv0 = 1;
                    end
                    turn = 1;
                end else if (w == 1) begin
                    e_r1 = 1;
                    if (req1_we) begin
                        e_load = 1; e_dr = req1_addr; e_bus = req1_wdata;
                        mregs[req1_addr] = req1_wdata;
                    end else begin
                        e_sr1 = req1_addr; nxt_rv1 = 1;
                    end
                    turn = 0;
                end
            end
            got  = {req0_ready, req1_ready, busy, rf_load, rf_dr, rf_bus, rf_sr1,
                    req0_rvalid, req1_rvalid, req0_rdata, req1_rdata};
            want = {e_r0, e_r1, e_busy, e_load, e_dr, e_bus, e_sr1,
                    cur_rv0, cur_rv1, cur_rd0, cur_rd1};
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL rand%0d got %h want %h", n, got, want);
            end
            if (nxt_rv0) cur_rd0 = mregs[e_sr1];
            if (nxt_rv1) cur_rd1 = mregs[e_sr1];
            cur_rv0 = nxt_rv0;
            cur_rv1 = nxt_rv1;
            cyc();
        end
        idle_inputs();
    endtask

    initial begin
        Reset = 1'b1;
        idle_inputs();
        #1;
        test_reset();
        test_write_read();
        test_alternate();
        test_back_to_back();
        test_clear_start();
        test_reset_mid_clear();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
